// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
// Latency: none, plain wires.
// Backpressure: none; the ALU accepts operands every cycle.
interface alu_if;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] rd;
  logic        z;

  // execute stage drives operands and reads the registered result
  modport master (
    output rs1,
    output rs2,
    output funct3,
    output funct7,
    input  rd,
    input  z
  );

  // ALU consumes operands and drives the registered result
  modport slave (
    input  rs1,
    input  rs2,
    input  funct3,
    input  funct7,
    output rd,
    output z
  );
endinterface

// File: rtl/alu.sv
// RV32I register-register ALU (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND).
// Latency: one cycle; result and non-zero flag are registered.
// Backpressure: none; new operands are taken every cycle, never stalls.
module alu (
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SRLSRA = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  logic [31:0] r;
  logic [31:0] rd_q;
  logic        z_q;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic [31:0] sra_res;

  // only the low five bits of rs2 matter for shifts; upper bits are ignored
  assign shamt = bus.rs2[4:0];

  assign lt_s = $signed(bus.rs1) < $signed(bus.rs2);
  assign lt_u = bus.rs1 < bus.rs2;

  // kept in its own signed expression so the sign fill is not lost to
  // unsigned context promotion inside the mux below
  assign sra_res = $signed(bus.rs1) >>> shamt;

  // combinational result selection; funct7 only matters for add/sub and shifts right
  always_comb begin
    r = 32'h0;
    case (bus.funct3)
      F3_ADDSUB: begin
        if (bus.funct7) r = bus.rs1 - bus.rs2;
        else            r = bus.rs1 + bus.rs2;
      end
      F3_SLL:    r = bus.rs1 << shamt;
      F3_SLT:    r = {31'h0, lt_s};
      F3_SLTU:   r = {31'h0, lt_u};
      F3_XOR:    r = bus.rs1 ^ bus.rs2;
      F3_SRLSRA: begin
        if (bus.funct7) r = sra_res;
        else            r = bus.rs1 >> shamt;
      end
      F3_OR:     r = bus.rs1 | bus.rs2;
      F3_AND:    r = bus.rs1 & bus.rs2;
      default:   r = 32'h0;
    endcase
  end

  // register result and non-zero flag; reset clears both immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 32'h0;
      z_q  <= 1'b0;
    end else begin
      rd_q <= r;
      z_q  <= (r != 32'h0);
    end
  end

  assign bus.rd = rd_q;
  assign bus.z  = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the RV32I ALU.
// Latency: checks each result #1 after the edge that registers it.
// Backpressure: none exercised; operands change every cycle.
module tb_alu;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rs1    = a;
    bus.rs2    = b;
  endtask

  task automatic check(input string tag, input logic [31:0] exp_rd, input logic exp_z);
    total++;
    assert (bus.rd === exp_rd) passed++;
    else $error("FAIL %s rd: got %h expected %h", tag, bus.rd, exp_rd);
    total++;
    assert (bus.z === exp_z) passed++;
    else $error("FAIL %s z: got %b expected %b", tag, bus.z, exp_z);
  endtask

  // apply operands, let one edge register them, then check
  task automatic step(input string tag, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_rd, input logic exp_z);
    drive(f3, f7, a, b);
    @(posedge clk);
    #1;
    check(tag, exp_rd, exp_z);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    drive(3'b000, 1'b0, 32'd20, 32'd30);

    // reset state, and reset holds across an edge even with a live result
    #3;
    check("reset_init", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 1'b0);
    rst = 1'b0;

    // add/sub
    step("add",       3'b000, 1'b0, 32'd20, 32'd30, 32'd50, 1'b1);
    step("sub",       3'b000, 1'b1, 32'd8,  32'd3,  32'd5,  1'b1);
    step("sub_wrap",  3'b000, 1'b1, 32'd0,  32'd1,  32'hFFFF_FFFF, 1'b1);
    step("sub_zero",  3'b000, 1'b1, 32'd20, 32'd20, 32'h0,  1'b0);

    // shifts
    step("sll",       3'b001, 1'b0, 32'd8, 32'd3, 32'd64, 1'b1);
    step("srl",       3'b101, 1'b0, 32'd8, 32'd3, 32'd1,  1'b1);
    step("sra",       3'b101, 1'b1, 32'd8, 32'd3, 32'd1,  1'b1);
    step("sra_neg",   3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
    step("srl_neg",   3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b1);
    step("sll_35",    3'b001, 1'b0, 32'd8, 32'd35, 32'd64, 1'b1);
    step("sra_by32",  3'b101, 1'b1, 32'h8000_0000, 32'd32, 32'h8000_0000, 1'b1);
    step("sll_f7",    3'b001, 1'b1, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b1);

    // compares
    step("slt",       3'b010, 1'b0, 32'd8, 32'd3, 32'd0, 1'b0);
    step("sltu",      3'b011, 1'b0, 32'd8, 32'd3, 32'd0, 1'b0);
    step("slt_neg",   3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
    step("sltu_neg",  3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    step("sltu_true", 3'b011, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1);

    // logic
    step("or",        3'b110, 1'b0, 32'd20, 32'd30, 32'd30, 1'b1);
    step("and",       3'b111, 1'b0, 32'd20, 32'd30, 32'd20, 1'b1);
    step("xor",       3'b100, 1'b0, 32'd20, 32'd30, 32'd10, 1'b1);
    step("or_f7",     3'b110, 1'b1, 32'd20, 32'd30, 32'd30, 1'b1);
    step("xor_zero",  3'b100, 1'b0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 1'b0);

    // mid-stream reset between edges clears at once, release loads next result
    step("add_pre",   3'b000, 1'b0, 32'd20, 32'd30, 32'd50, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_mid_hold", 32'h0, 1'b0);
    drive(3'b100, 1'b0, 32'd20, 32'd30);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 32'd10, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
